rf_writeback_ctrl: RTL and testbench

//  Write-side initiator for the 32x32 register file (DL1/DL2/DE/Dato/WE bank).
//  - Accepts results from two producers (ALU, load unit) over valid/ready.
//  - Arbitrates between them and drives the single write port DE/Dato/WE from registers.
//  - Keeps a pending-write scoreboard that the issue stage queries on the read addresses.

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_wb_hold.sv | 37 +++
 rtl/rf_writeback_ctrl.sv | 126 ++++++++++++
 tb/tb_rf_writeback_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared widths and types for the register-file write-back path.
package rf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LD
  } wb_src_e;

endpackage

// File: rtl/rf_wb_hold.sv
// One-entry valid/ready holding register for a write-back producer.
// A full entry that is granted this cycle accepts a refill on the same edge.
module rf_wb_hold
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [ADDR_W-1:0] src_dest,
  input  logic [DATA_W-1:0] src_data,
  input  logic              grant,
  output logic              hold_valid,
  output logic [ADDR_W-1:0] hold_dest,
  output logic [DATA_W-1:0] hold_data
);

  logic valid_reg;

  assign src_ready  = !rst && (!valid_reg || grant);
  assign hold_valid = valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      hold_dest <= '0;
      hold_data <= '0;
    end else if (src_valid && src_ready) begin
      valid_reg <= 1'b1;
      hold_dest <= src_dest;
      hold_data <= src_data;
    end else if (grant) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Write-back controller: arbitrates ALU and load results onto the single
// register-file write port and tracks pending destinations for issue.
module rf_writeback_ctrl
  import rf_pkg::*;
#(
  parameter int STARVE_MAX  = 2,
  parameter int ZERO_REG_RO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_dest,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dest,
  input  logic [ADDR_W-1:0] DL1,
  input  logic [ADDR_W-1:0] DL2,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W-1:0] DE,
  output logic [DATA_W-1:0] Dato,
  output logic              WE
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic              alu_hv, ld_hv;
  logic [ADDR_W-1:0] alu_hd, ld_hd;
  logic [DATA_W-1:0] alu_hdata, ld_hdata;
  wb_src_e           grant_src;
  wb_entry_t         win;
  logic              any_grant, zero_wr;
  logic [CNT_W-1:0]  starve_cnt_reg;
  logic [NREG-1:0]   pending_reg, set_vec, clr_vec;

  rf_wb_hold u_alu_hold (
    .clk(clk), .rst(rst),
    .src_valid(alu_valid), .src_ready(alu_ready),
    .src_dest(alu_dest), .src_data(alu_data),
    .grant(grant_src == SRC_ALU),
    .hold_valid(alu_hv), .hold_dest(alu_hd), .hold_data(alu_hdata)
  );

  rf_wb_hold u_ld_hold (
    .clk(clk), .rst(rst),
    .src_valid(ld_valid), .src_ready(ld_ready),
    .src_dest(ld_dest), .src_data(ld_data),
    .grant(grant_src == SRC_LD),
    .hold_valid(ld_hv), .hold_dest(ld_hd), .hold_data(ld_hdata)
  );

  // Load wins ties so memory latency stays short; the counter bounds ALU waiting.
  always_comb begin
    grant_src = SRC_NONE;
    win       = '0;
    if (alu_hv && ld_hv) begin
      grant_src = (starve_cnt_reg == CNT_W'(STARVE_MAX)) ? SRC_ALU : SRC_LD;
    end else if (alu_hv) begin
      grant_src = SRC_ALU;
    end else if (ld_hv) begin
      grant_src = SRC_LD;
    end
    if (grant_src == SRC_ALU) begin
      win.dest = alu_hd;
      win.data = alu_hdata;
    end else if (grant_src == SRC_LD) begin
      win.dest = ld_hd;
      win.data = ld_hdata;
    end
  end

  assign any_grant = (grant_src != SRC_NONE);
  assign zero_wr   = (ZERO_REG_RO != 0) && (win.dest == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else if (!alu_hv || grant_src == SRC_ALU) begin
      starve_cnt_reg <= '0;
    end else if (grant_src == SRC_LD) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end

  // Register-0 writes retire silently: WE stays low and DE/Dato keep their values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WE   <= 1'b0;
      DE   <= '0;
      Dato <= '0;
    end else if (any_grant && !zero_wr) begin
      WE   <= 1'b1;
      DE   <= win.dest;
      Dato <= win.data;
    end else begin
      WE   <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_pending
      assign set_vec[gi] = iss_valid && (iss_dest == ADDR_W'(gi)) &&
                           !((ZERO_REG_RO != 0) && (gi == 0));
      assign clr_vec[gi] = any_grant && (win.dest == ADDR_W'(gi));

      // A same-cycle issue to the retiring register keeps the bit set.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pending_reg[gi] <= 1'b0;
        end else begin
          pending_reg[gi] <= set_vec[gi] || (pending_reg[gi] && !clr_vec[gi]);
        end
      end
    end
  endgenerate

  assign busy1 = pending_reg[DL1];
  assign busy2 = pending_reg[DL2];

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed bench for rf_writeback_ctrl with hand-computed expectations.
module tb_rf_writeback_ctrl;
  import rf_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid, ld_valid, iss_valid;
  logic              alu_ready, ld_ready;
  logic [ADDR_W-1:0] alu_dest, ld_dest, iss_dest, DL1, DL2;
  logic [DATA_W-1:0] alu_data, ld_data;
  logic              busy1, busy2;
  logic [ADDR_W-1:0] DE;
  logic [DATA_W-1:0] Dato;
  logic              WE;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_writeback_ctrl #(.STARVE_MAX(2), .ZERO_REG_RO(1)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_dest(iss_dest),
    .DL1(DL1), .DL2(DL2), .busy1(busy1), .busy2(busy2),
    .DE(DE), .Dato(Dato), .WE(WE)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_dest = '0; alu_data = '0;
    ld_valid = 0;  ld_dest = '0;  ld_data = '0;
    iss_valid = 0; iss_dest = '0; DL1 = '0; DL2 = '0;
    step(); step();

    // Reset state
    check("rst_we", 32'(WE), 0);
    check("rst_de", 32'(DE), 0);
    check("rst_dato", Dato, 0);
    check("rst_alu_ready", 32'(alu_ready), 0);
    check("rst_ld_ready", 32'(ld_ready), 0);
    rst = 1'b0;
    #1;
    check("post_rst_alu_ready", 32'(alu_ready), 1);

    // 1. ALU only
    alu_valid = 1; alu_dest = 5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 0;
    check("t1_we_early", 32'(WE), 0);
    step();
    check("t1_we", 32'(WE), 1);
    check("t1_de", 32'(DE), 5);
    check("t1_dato", Dato, 32'hDEADBEEF);
    step();
    check("t1_we_pulse", 32'(WE), 0);

    // 2. Contention: load first, then ALU
    alu_valid = 1; alu_dest = 3; alu_data = 32'h33;
    ld_valid = 1;  ld_dest = 4;  ld_data = 32'h44;
    step();
    alu_valid = 0; ld_valid = 0;
    step();
    check("t2_we_a", 32'(WE), 1);
    check("t2_de_a", 32'(DE), 4);
    check("t2_dato_a", Dato, 32'h44);
    step();
    check("t2_we_b", 32'(WE), 1);
    check("t2_de_b", 32'(DE), 3);
    check("t2_dato_b", Dato, 32'h33);
    step();
    check("t2_idle", 32'(WE), 0);

    // 3. Starvation: ALU loses twice, then wins
    alu_valid = 1; alu_dest = 7; alu_data = 32'h77;
    ld_valid = 1;  ld_dest = 10; ld_data = 32'h110;
    step();
    alu_valid = 0; ld_dest = 11; ld_data = 32'h111;
    step();
    check("t3_de_1", 32'(DE), 10);
    ld_dest = 12; ld_data = 32'h112;
    step();
    check("t3_de_2", 32'(DE), 11);
    check("t3_ld_blocked", 32'(ld_ready), 0);
    ld_valid = 0;
    step();
    check("t3_we_3", 32'(WE), 1);
    check("t3_de_3", 32'(DE), 7);
    check("t3_dato_3", Dato, 32'h77);
    step();
    check("t3_de_4", 32'(DE), 12);
    step();
    check("t3_idle", 32'(WE), 0);

    // 4. Scoreboard
    iss_valid = 1; iss_dest = 9; DL1 = 9; DL2 = 8;
    step();
    iss_valid = 0;
    check("t4_busy1_set", 32'(busy1), 1);
    check("t4_busy2_clr", 32'(busy2), 0);
    alu_valid = 1; alu_dest = 9; alu_data = 32'h91;
    step();
    alu_valid = 0;
    check("t4_busy1_inflight", 32'(busy1), 1);
    step();
    check("t4_we", 32'(WE), 1);
    check("t4_busy1_cleared", 32'(busy1), 0);
    alu_valid = 1; alu_data = 32'h99;
    step();
    alu_valid = 0; iss_valid = 1; iss_dest = 9;
    step();
    iss_valid = 0;
    check("t4_we2", 32'(WE), 1);
    check("t4_set_wins", 32'(busy1), 1);

    // 5. Register zero
    alu_valid = 1; alu_dest = 0; alu_data = 32'h1;
    iss_valid = 1; iss_dest = 0; DL2 = 0;
    #1;
    check("t5_alu_ready", 32'(alu_ready), 1);
    step();
    alu_valid = 0; iss_valid = 0;
    check("t5_pending0", 32'(busy2), 0);
    step();
    check("t5_we", 32'(WE), 0);
    check("t5_de_hold", 32'(DE), 9);
    check("t5_dato_hold", Dato, 32'h99);
    step();
    check("t5_we_after", 32'(WE), 0);
    check("t5_freed", 32'(alu_ready), 1);

    // 6. Reset mid-flight
    alu_valid = 1; alu_dest = 20; alu_data = 32'hA0;
    ld_valid = 1;  ld_dest = 21;  ld_data = 32'hB1;
    iss_valid = 1; iss_dest = 20; DL1 = 20; DL2 = 9;
    step();
    alu_valid = 0; iss_valid = 0;
    ld_dest = 22; ld_data = 32'hB2;
    check("t6_busy1_pre", 32'(busy1), 1);
    step();
    ld_valid = 0;
    check("t6_we_pre", 32'(WE), 1);
    check("t6_de_pre", 32'(DE), 21);
    #2;
    rst = 1'b1;
    #1;
    check("t6_we_drop", 32'(WE), 0);
    check("t6_de_rst", 32'(DE), 0);
    check("t6_busy1", 32'(busy1), 0);
    check("t6_busy2", 32'(busy2), 0);
    check("t6_alu_ready", 32'(alu_ready), 0);
    check("t6_ld_ready", 32'(ld_ready), 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t6_no_write_%0d", i), 32'(WE), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
